// File: rtl/byte_serial_adder_pkg.sv
// Shared definitions for the byte-serial adder: slice width and FSM state encodings.
package byte_serial_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/eight_bit_full_adder.sv
// 8-bit ripple full adder: {Carry, Sum} = A + B + Cin.
module eight_bit_full_adder (
    output logic       Carry,
    output logic [7:0] Sum,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin
);

    assign {Carry, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-cycle wide adder: adds two NBYTES-byte operands one byte per cycle
// through a single eight_bit_full_adder, carrying between bytes in a register.
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [W-1:0]      a_lat, b_lat;
    logic              carry_reg;
    logic [BYTE_W-1:0] add_sum;
    logic              add_carry;
    logic              accept;
    logic              last_byte;

    // Handshake outputs depend on state alone, so there is no input-to-output path.
    assign ready     = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state == S_ADD);
    assign done      = (state == S_DONE);
    assign accept    = ready && start;
    assign last_byte = (idx == LAST_IDX);

    eight_bit_full_adder u_adder (
        .Carry (add_carry),
        .Sum   (add_sum),
        .A     (a_lat[BYTE_W*idx +: BYTE_W]),
        .B     (b_lat[BYTE_W*idx +: BYTE_W]),
        .Cin   (carry_reg)
    );

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_ADD;
            S_ADD:   if (last_byte) state_next = S_DONE;
            S_DONE:  state_next = start ? S_ADD : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            a_lat     <= a;
            b_lat     <= b;
            carry_reg <= cin;
            cout      <= 1'b0;
        end else if (state == S_ADD) begin
            sum[BYTE_W*idx +: BYTE_W] <= add_sum;
            carry_reg                 <= add_carry;
            if (last_byte) begin
                cout <= add_carry;
                idx  <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder: directed vectors on a 4-byte instance
// plus random sweeps on 4-byte and 2-byte instances.
module tb_byte_serial_adder;

    localparam int NB  = 4;
    localparam int W   = 8 * NB;
    localparam int NB2 = 2;
    localparam int W2  = 8 * NB2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, cin, ready, busy, done, cout;
    logic [W-1:0]  a, b, sum;
    logic          start2, cin2, ready2, busy2, done2, cout2;
    logic [W2-1:0] a2, b2, sum2;

    byte_serial_adder #(.NBYTES(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    byte_serial_adder #(.NBYTES(NB2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [W:0] res;
        int         cyc;
    } exp_t;

    exp_t        q4[$];
    logic [W2:0] q2[$];

    // One cycle of stimulus for the 4-byte instance; pushes the expectation when accepted.
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic r, input logic [W:0] exp);
        @(negedge clk);
        start = s; a = av; b = bv; cin = c; reset = r;
        if (r) q4.delete();
        else if (s && ready) q4.push_back('{exp, cyc});
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60 && q4.size() != 0; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        if (q4.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d results outstanding", name, q4.size());
            q4.delete();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Monitor for the 4-byte instance: results, latency, busy length, result hold.
    int          busy_cnt = 0;
    logic        hold     = 1'b0;
    logic [W:0]  held;
    always @(negedge clk) begin
        if (done) begin
            check("busy_cycles", 64'(busy_cnt), 64'(NB));
            busy_cnt = 0;
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got sum=%0h cout=%0b with nothing expected", sum, cout);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("result", 64'({cout, sum}), 64'(e.res));
                check("latency", 64'(cyc - e.cyc), 64'(NB + 1));
            end
            held = {cout, sum};
            hold = 1'b1;
        end else if (busy) begin
            hold = 1'b0;
            busy_cnt++;
        end else if (ready) begin
            busy_cnt = 0;
            if (hold) check("hold", 64'({cout, sum}), 64'(held));
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done2: got sum=%0h cout=%0b", sum2, cout2);
            end else begin
                check("result2", 64'({cout2, sum2}), 64'(q2.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        start = 0; a = '0; b = '0; cin = 0; reset = 1;
        start2 = 0; a2 = '0; b2 = '0; cin2 = 0;
        drive(1'b1, 32'd7, 32'd9, 1'b1, 1'b1, '0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, '0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_sum",   64'({cout, sum}), 64'd0);
        check("rst_ready2", 64'(ready2), 64'd1);

        // Single add with carry-in
        drive(1'b1, 32'd100, 32'd100, 1'b1, 1'b0, 33'd201);
        wait_empty("t1");

        // Carry ripple through all bytes, then carries into isolated bytes
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000);
        wait_empty("t2a");
        drive(1'b1, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 33'h0_0100_0100);
        wait_empty("t2b");

        // Start held high: back-to-back acceptance in the DONE cycle
        for (int i = 0; i < 11; i++) drive(1'b1, 32'd255, 32'd255, 1'b0, 1'b0, 33'd510);
        wait_empty("t3");

        // Start while busy is ignored; operands may change mid-operation
        drive(1'b1, 32'd5, 32'd6, 1'b1, 1'b0, 33'd12);
        drive(1'b0, 32'd5, 32'd6, 1'b1, 1'b0, '0);
        drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 33'd3);
        drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, '0);
        wait_empty("t4");

        // Reset at byte 2 abandons the operation
        drive(1'b1, 32'd20, 32'd200, 1'b0, 1'b0, 33'd220);
        drive(1'b0, 32'd20, 32'd200, 1'b0, 1'b0, '0);
        drive(1'b0, 32'd20, 32'd200, 1'b0, 1'b0, '0);
        drive(1'b0, 32'd20, 32'd200, 1'b0, 1'b1, '0);
        drive(1'b0, 32'd20, 32'd200, 1'b0, 1'b0, '0);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_busy",  64'(busy),  64'd0);
        check("midrst_done",  64'(done),  64'd0);
        check("midrst_sum",   64'({cout, sum}), 64'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        drive(1'b1, 32'd20, 32'd200, 1'b0, 1'b0, 33'd220);
        wait_empty("t5");

        // Random sweeps on both widths
        fork
            begin
                for (int i = 0; i < 6000; i++) begin
                    logic [W-1:0] ra, rb;
                    logic         rc;
                    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
                    drive(1'($urandom_range(0, 1)), ra, rb, rc, 1'b0,
                          {1'b0, ra} + {1'b0, rb} + {32'b0, rc});
                end
                wait_empty("sweep4");
            end
            begin
                for (int i = 0; i < 3500; i++) begin
                    @(negedge clk);
                    start2 = 1'($urandom_range(0, 1));
                    a2     = W2'($urandom);
                    b2     = W2'($urandom);
                    cin2   = 1'($urandom_range(0, 1));
                    if (start2 && ready2)
                        q2.push_back({1'b0, a2} + {1'b0, b2} + {16'b0, cin2});
                end
                @(negedge clk);
                start2 = 1'b0;
                for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
                if (q2.size() != 0) begin
                    checks++; errors++;
                    $display("FAIL sweep2_timeout: %0d results outstanding", q2.size());
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
